regfile_bank: RTL

Parametrised, multi-entry successor to the single 16-bit enable register: a bank of DEPTH registers, each WIDTH bits wide. It has one byte-maskable write port, two combinational read ports, a sequential clear engine and an optional shadow bank for interrupt context save and restore. It sits in the datapath beside the ALU and feeds operand buses A and B. As on the rest of the datapath, all state updates on the falling edge of the clock.

---
 rtl/regfile_bank.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_bank.sv
// regfile_bank: a bank of DEPTH registers of WIDTH bits each, sitting beside the ALU.
//
// Ports:
//   - One byte-maskable write port.
//   - Two combinational read ports that feed operand buses A and B.
//   - A sequential clear engine.
//
// Optional feature, macro REGFILE_SHADOW_EN:
//   - Adds a shadow bank for interrupt context save, restore and swap.
//   - Without the macro, the save and restore inputs are accepted but ignored.
//
// Clocking and reset:
//   - All state changes on the falling edge of clk.
//   - rst_n is asynchronous and active-low.
//
// Request semantics:
//   - we, clr, save and restore are levels sampled at each falling edge.
//   - There is no ready signal. While busy=1, every request is ignored.
//   - The caller holds a request until busy is low to be sure it lands.
//
// Parameter limits:
//   - WIDTH must be a multiple of 8.
//   - DEPTH must be at least 2.
//   - Neither limit is checked here.
module regfile_bank #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] wbe,
   input  logic [AW-1:0]      raddr_a,
   output logic [WIDTH-1:0]   rdata_a,
   input  logic [AW-1:0]      raddr_b,
   output logic [WIDTH-1:0]   rdata_b,
   input  logic               clr,
   output logic               busy,
   input  logic               save,
   input  logic               restore
);

   localparam int NB = WIDTH / 8;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] bank [DEPTH];
   logic [0:0]       state;
   logic [AW-1:0]    ptr;

   logic             idle;
   logic             clr_go;
   logic             waddr_ok;
   logic             rd_ok_a;
   logic             rd_ok_b;
   logic             wr_go;
   logic [WIDTH-1:0] wr_mask;
   logic [WIDTH-1:0] wr_merged;

`ifdef REGFILE_SHADOW_EN
   logic [WIDTH-1:0] shadow [DEPTH];
   logic             save_go;
   logic             restore_go;
`else
   logic             unused_sr;
   assign unused_sr = save | restore;
`endif

   assign idle = (state == S_IDLE);
   assign busy = (state == S_CLEAR);

   // Request decode. clr beats everything, and restore beats a write.
   always_comb begin
      clr_go   = idle & clr;
      waddr_ok = (32'(waddr) < DEPTH);
`ifdef REGFILE_SHADOW_EN
      save_go    = idle & ~clr & save;
      restore_go = idle & ~clr & restore;
      wr_go      = idle & ~clr & ~restore & we & waddr_ok;
`else
      wr_go      = idle & ~clr & we & waddr_ok;
`endif
   end

   // Expand the byte enables into a bit mask.
   // Merge the selected bytes of wdata into the current entry.
   always_comb begin
      wr_mask   = '0;
      wr_merged = '0;
      for (int i = 0; i < NB; i++) begin
         wr_mask[8*i +: 8] = {8{wbe[i]}};
      end
      if (waddr_ok) begin
         wr_merged = (bank[waddr] & ~wr_mask) | (wdata & wr_mask);
      end
   end

   // Clear sequencer.
   // The accepting edge already clears entry 0, so the pointer moves on to 1.
   // That makes the whole sweep take exactly DEPTH falling edges.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ptr   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (clr) begin
                  state <= S_CLEAR;
                  ptr   <= PTR_ONE;
               end
            end
            S_CLEAR: begin
               if (ptr == PTR_LAST) begin
                  state <= S_IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + PTR_ONE;
               end
            end
            default: begin
               state <= S_IDLE;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Bank update: clear sweep, restore from shadow, or a byte-masked write.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= '0;
         end
      end else if (state == S_CLEAR) begin
         bank[ptr] <= '0;
      end else if (clr_go) begin
         bank[0] <= '0;
`ifdef REGFILE_SHADOW_EN
      end else if (restore_go) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank[i] <= shadow[i];
         end
`endif
      end else if (wr_go) begin
         bank[waddr] <= wr_merged;
      end
   end

`ifdef REGFILE_SHADOW_EN
   // Shadow capture.
   // The shadow takes the pre-edge bank, so save+write keeps the old value.
   // save+restore swaps the two banks.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow[i] <= '0;
         end
      end else if (save_go) begin
         for (int i = 0; i < DEPTH; i++) begin
            shadow[i] <= bank[i];
         end
      end
   end
`endif

   // Read ports are combinational.
   // An address beyond the last entry reads as zero.
   always_comb begin
      rd_ok_a = (32'(raddr_a) < DEPTH);
      rd_ok_b = (32'(raddr_b) < DEPTH);
      rdata_a = '0;
      rdata_b = '0;
      if (rd_ok_a) begin
         rdata_a = bank[raddr_a];
      end
      if (rd_ok_b) begin
         rdata_b = bank[raddr_b];
      end
   end

endmodule
